// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - register offsets and TYPE encodings shared by irq_ctrl
package irq_ctrl_pkg;

  localparam logic [1:0] IRQ_STATUS  = 2'd0;
  localparam logic [1:0] IRQ_ENABLE  = 2'd1;
  localparam logic [1:0] IRQ_TYPE    = 2'd2;
  localparam logic [1:0] IRQ_PENDING = 2'd3;

  localparam logic TYPE_EDGE  = 1'b1;
  localparam logic TYPE_LEVEL = 1'b0;

endpackage

// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - shared 5-bit address / 8-bit data CSR bus
interface irq_ctrl_if;

  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;

  modport master (output csr_a, output csr_di, output csr_we, input csr_do);
  modport slave  (input csr_a, input csr_di, input csr_we, output csr_do);

endinterface

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - 2-FF synchroniser plus one history flop per bit, gives level and rising edge
module irq_sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] hist_q, hist_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign s    = sync_q;
  assign rise = sync_q & ~hist_q;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - sticky interrupt status with enable/type masks and a re-trigger gap on irq_out
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR  = 5'h18,
  parameter int         NUM_IRQS   = 8,
  parameter int         GAP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  irq_ctrl_if.slave           csr,
  input  logic [NUM_IRQS-1:0] irq_in,
  output logic                irq_out
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [NUM_IRQS-1:0] s, rise, set, w1c, wdata;
  logic [NUM_IRQS-1:0] status_q, status_d, enable_q, enable_d, type_q, type_d;
  logic [NUM_IRQS-1:0] pend_now, pend_next;
  logic [GW-1:0]       gap_q, gap_d;
  logic                irq_out_q, irq_out_d;
  logic [4:0]          off;
  logic                in_win, wr_status, wr_enable, wr_type;
  logic [7:0]          rdata;

  irq_sync_edge #(.WIDTH(NUM_IRQS)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (irq_in),
    .s    (s),
    .rise (rise)
  );

  // Unsigned wrap makes addresses below the base land far outside the window.
  assign off       = csr.csr_a - BASE_ADDR;
  assign in_win    = off < 5'd4;
  assign wdata     = csr.csr_di[NUM_IRQS-1:0];
  assign wr_status = csr.csr_we && in_win && (off[1:0] == IRQ_STATUS);
  assign wr_enable = csr.csr_we && in_win && (off[1:0] == IRQ_ENABLE);
  assign wr_type   = csr.csr_we && in_win && (off[1:0] == IRQ_TYPE);

  always_comb begin
    set = '0;
    for (int i = 0; i < NUM_IRQS; i++) begin
      set[i] = (type_q[i] == TYPE_EDGE) ? rise[i] : s[i];
    end
    w1c       = wr_status ? wdata : '0;
    status_d  = (status_q & ~w1c) | set;
    enable_d  = wr_enable ? wdata : enable_q;
    type_d    = wr_type ? wdata : type_q;
    pend_now  = status_q & enable_q;
    pend_next = status_d & enable_d;
    // Gap only when the host already saw a request and another one is still waiting.
    if ((wr_status || wr_enable) && (|pend_now) && (|pend_next)) begin
      gap_d = GW'(GAP_CYCLES);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end else begin
      gap_d = gap_q;
    end
    irq_out_d = (|pend_now) && (gap_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q  <= '0;
      enable_q  <= '0;
      type_q    <= '0;
      gap_q     <= '0;
      irq_out_q <= 1'b0;
    end else begin
      status_q  <= status_d;
      enable_q  <= enable_d;
      type_q    <= type_d;
      gap_q     <= gap_d;
      irq_out_q <= irq_out_d;
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (in_win) begin
      case (off[1:0])
        IRQ_STATUS:  rdata = 8'(status_q);
        IRQ_ENABLE:  rdata = 8'(enable_q);
        IRQ_TYPE:    rdata = 8'(type_q);
        IRQ_PENDING: rdata = 8'(pend_now);
        default:     rdata = 8'h00;
      endcase
    end
  end

  assign csr.csr_do = rdata;
  assign irq_out    = irq_out_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed and randomized bench for irq_ctrl against a register-level model
module tb_irq_ctrl;

  localparam logic [4:0] BASE = 5'h18;
  localparam int         GAP  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irq_in = 8'h00;
  logic       irq_out;

  irq_ctrl_if bus();

  irq_ctrl #(.BASE_ADDR(BASE), .NUM_IRQS(8), .GAP_CYCLES(GAP)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .csr    (bus),
    .irq_in (irq_in),
    .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_status, m_enable, m_type;
  logic [7:0] m_smp0, m_smp1, m_smp2;
  int         m_gap;
  logic       m_irq;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_status = 8'h00; m_enable = 8'h00; m_type = 8'h00;
    m_smp0 = 8'h00; m_smp1 = 8'h00; m_smp2 = 8'h00;
    m_gap = 0; m_irq = 1'b0;
  endtask

  function automatic logic [7:0] model_rd(input logic [4:0] a);
    logic [4:0] o;
    o = a - BASE;
    case (o)
      5'd0:    return m_status;
      5'd1:    return m_enable;
      5'd2:    return m_type;
      5'd3:    return m_status & m_enable;
      default: return 8'h00;
    endcase
  endfunction

  // Source seen by the core is irq_in two clocks late; edge = that value vs one clock earlier.
  task automatic model_step();
    logic [4:0] o;
    logic [7:0] lvl, edg, setv, clr, ns, ne, pre;
    o    = bus.csr_a - BASE;
    lvl  = m_smp1;
    edg  = m_smp1 & ~m_smp2;
    setv = (m_type & edg) | (~m_type & lvl);
    clr  = (bus.csr_we && o == 5'd0) ? bus.csr_di : 8'h00;
    ns   = (m_status & ~clr) | setv;
    ne   = (bus.csr_we && o == 5'd1) ? bus.csr_di : m_enable;
    pre  = m_status & m_enable;
    m_irq = (pre != 0) && (m_gap == 0);
    if (bus.csr_we && (o == 5'd0 || o == 5'd1) && pre != 0 && (ns & ne) != 0) m_gap = GAP;
    else if (m_gap > 0) m_gap = m_gap - 1;
    if (bus.csr_we && o == 5'd2) m_type = bus.csr_di;
    m_status = ns;
    m_enable = ne;
    m_smp2 = m_smp1; m_smp1 = m_smp0; m_smp0 = irq_in;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check("irq_out", {7'b0, irq_out}, {7'b0, m_irq});
    check("csr_do", bus.csr_do, model_rd(bus.csr_a));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus.csr_a = a; bus.csr_di = d; bus.csr_we = 1'b1;
    tick();
    bus.csr_we = 1'b0;
  endtask

  task automatic rd_const(input string tag, input logic [4:0] a, input logic [7:0] exp);
    bus.csr_a = a;
    #1;
    check(tag, bus.csr_do, exp);
  endtask

  initial begin
    logic [7:0] sv_st, sv_en, sv_ty;
    bus.csr_a = 5'h00; bus.csr_di = 8'h00; bus.csr_we = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) rd_const("rst_reg", 5'(BASE + i), 8'h00);

    // level source, sticky while high
    wr(BASE + 5'd1, 8'h01);
    wr(BASE + 5'd2, 8'h00);
    irq_in = 8'h01;
    idle(3);
    check("lvl_not_yet", {7'b0, irq_out}, 8'h00);
    idle(1);
    check("lvl_irq", {7'b0, irq_out}, 8'h01);
    rd_const("lvl_status", BASE, 8'h01);
    idle(5);
    wr(BASE, 8'h01);
    rd_const("lvl_w1c_high", BASE, 8'h01);
    irq_in = 8'h00;
    idle(6);
    wr(BASE, 8'h01);
    rd_const("lvl_w1c_low", BASE, 8'h00);
    tick();
    check("lvl_irq_off", {7'b0, irq_out}, 8'h00);

    // edge source held high
    wr(BASE + 5'd2, 8'h02);
    wr(BASE + 5'd1, 8'h02);
    irq_in = 8'h02;
    idle(6);
    rd_const("edge_status", BASE, 8'h02);
    wr(BASE, 8'h02);
    idle(44);
    rd_const("edge_cleared", BASE, 8'h00);
    check("edge_irq_off", {7'b0, irq_out}, 8'h00);
    irq_in = 8'h00;
    idle(4);

    // masking
    wr(BASE + 5'd1, 8'h00);
    irq_in = 8'h08;
    idle(3);
    irq_in = 8'h00;
    idle(4);
    rd_const("mask_status", BASE, 8'h08);
    rd_const("mask_pending", BASE + 5'd3, 8'h00);
    check("mask_irq", {7'b0, irq_out}, 8'h00);
    wr(BASE + 5'd1, 8'h08);
    tick();
    check("unmask_irq", {7'b0, irq_out}, 8'h01);

    // gap after W1C with another source still pending
    wr(BASE + 5'd1, 8'h00);
    wr(BASE, 8'hff);
    wr(BASE + 5'd2, 8'h00);
    irq_in = 8'h03;
    idle(3);
    irq_in = 8'h00;
    idle(4);
    wr(BASE + 5'd1, 8'h03);
    tick();
    wr(BASE, 8'h01);
    for (int i = 0; i < GAP; i++) begin
      tick();
      check("gap_low", {7'b0, irq_out}, 8'h00);
    end
    tick();
    check("gap_end", {7'b0, irq_out}, 8'h01);
    rd_const("gap_pending", BASE + 5'd3, 8'h02);

    // set and W1C on the same bit in the same cycle
    wr(BASE + 5'd2, 8'h04);
    idle(2);
    irq_in = 8'h04;
    tick();
    tick();
    wr(BASE, 8'h04);
    bus.csr_a = BASE;
    #1;
    check("race_set_wins", bus.csr_do & 8'h04, 8'h04);
    irq_in = 8'h00;
    idle(4);

    // window edges
    rd_const("win_above", BASE + 5'd4, 8'h00);
    rd_const("win_below", BASE - 5'd1, 8'h00);
    sv_st = m_status; sv_en = m_enable; sv_ty = m_type;
    wr(BASE + 5'd3, 8'hff);
    wr(BASE + 5'd4, 8'hff);
    rd_const("ro_status", BASE, sv_st);
    rd_const("ro_enable", BASE + 5'd1, sv_en);
    rd_const("ro_type", BASE + 5'd2, sv_ty);

    // asynchronous reset while irq_out is high
    idle(6);
    check("pre_reset_irq", {7'b0, irq_out}, 8'h01);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("async_reset_irq", {7'b0, irq_out}, 8'h00);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) rd_const("post_reset_reg", 5'(BASE + i), 8'h00);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) irq_in = 8'($urandom);
      bus.csr_a  = 5'(int'(BASE) - 2 + $urandom_range(0, 7));
      bus.csr_di = 8'($urandom);
      bus.csr_we = ($urandom_range(0, 3) == 0);
      tick();
      bus.csr_we = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
